imem_arb: RTL and testbench
===========================

IMEM_ARB -- requirements
Module: imem_arb

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- ADDR_WIDTH, 32, requester byte-address width.
- DATA_WIDTH, 32, word width.
- MEM_DEPTH, 18, memory word-address width.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0_valid  in  1  fetch port request; read-only.
- req0_addr  in  ADDR_WIDTH  fetch byte address (PC).
- req0_ready  out  1  fetch request accepted this cycle.
- rsp0_valid  out  1  fetch response strobe.
- rsp0_data  out  DATA_WIDTH  fetched instruction word.
- rsp0_err  out  1  fetch address fault.
- req1_valid  in  1  loader/debug port request.
- req1_we  in  1  loader write enable (1 = write).
- req1_addr  in  ADDR_WIDTH  loader byte address.
- req1_wdata  in  DATA_WIDTH  loader write data.
- req1_ready, rsp1_valid, rsp1_data, rsp1_err  out  1/1/DATA_WIDTH/1  as for port 0.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write strobe.
- mem_addr  out  MEM_DEPTH  memory word address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_rdata  in  DATA_WIDTH  read data; valid the cycle after mem_en.

Function
REQ-003 The FSM SHALL have states IDLE, ISSUE, CAPT and RESP, advancing IDLE->ISSUE->CAPT->RESP->IDLE one state per cycle once a request is accepted.
REQ-004 Requests SHALL be accepted only in IDLE; reqN_ready SHALL be combinational, high only in IDLE when req N is valid and granted.
REQ-005 Arbitration SHALL be round-robin. On simultaneous valid, the port not granted last wins. last_grant SHALL reset to 1, so port 0 wins the first tie.
REQ-006 A single valid requester in IDLE SHALL be granted regardless of last_grant; last_grant SHALL update only on acceptance.
REQ-007 At acceptance (cycle T), the arbiter SHALL register port id, addr, we (forced 0 for port 0) and wdata. Requesters SHALL hold valid and payload stable until ready; withdrawal before ready is illegal.
REQ-008 A request SHALL be faulted if addr[1:0] != 0 or any bit addr[ADDR_WIDTH-1:MEM_DEPTH+2] is nonzero.
REQ-009 In ISSUE (T+1), a non-faulted request SHALL drive mem_en=1, mem_we=registered we, mem_addr=addr[MEM_DEPTH+1:2] and mem_wdata. A faulted request SHALL keep mem_en=0 and mem_we=0.
REQ-010 In CAPT (T+2), the arbiter SHALL register mem_rdata for a non-faulted read. Otherwise it SHALL register 0.
REQ-011 In RESP (T+3), rspN_valid SHALL be high for exactly one cycle on the granted port only, with rspN_data as registered and rspN_err = fault flag. The other port's rsp outputs SHALL stay 0.
REQ-012 A write SHALL return rsp1_valid with rsp1_data=0. A faulted write SHALL never assert mem_we.
REQ-013 Outside ISSUE, mem_en, mem_we, mem_addr and mem_wdata SHALL be 0.
REQ-014 Latency SHALL be fixed at 3 cycles (accept T -> rsp T+3). Peak throughput SHALL be one request per 4 cycles. The next acceptance is at the earliest T+4.
REQ-015 A continuously valid requester SHALL wait at most one other transaction before being granted.

Reset
REQ-016 rst SHALL asynchronously force:
- state=IDLE, last_grant=1.
- all rsp* outputs, mem_en, mem_we, mem_addr, mem_wdata and registered data to 0.
REQ-017 Reset mid-transaction SHALL abort it: no response is delivered, and mem_en/mem_we drop in the same cycle rst rises.
REQ-018 The first acceptance after reset release SHALL occur no earlier than the first rising clk edge with rst low.

Verification
REQ-019 Port 0 read addr 0x0000_0010, memory word 4 = 0xDEAD_BEEF -> req0_ready at T, mem_en with mem_addr=4 at T+1, rsp0_valid/rsp0_data=0xDEAD_BEEF/rsp0_err=0 at T+3.
REQ-020 Both ports valid continuously after reset -> grants alternate 0,1,0,1, with acceptances exactly 4 cycles apart.
REQ-021 Port 1 write addr 0x0000_0008, wdata 0x1234_5678, then port 0 read 0x8 -> mem_we at write T+1 with mem_addr=2, and the read returns 0x1234_5678.
REQ-022 Port 0 read addr 0x0000_0006, then addr 0x0100_0000 -> mem_en never asserted, rsp0_err=1 and rsp0_data=0 at T+3 for both.
REQ-023 rst asserted during CAPT of a read -> mem outputs 0 immediately, no rsp*_valid ever produced, port 0 wins the next tie.

Source files
------------

// File: rtl/imem_arb.sv
// imem_arb: two-port round-robin arbiter in front of a single-port instruction memory.
// Each accepted request runs IDLE->ISSUE->CAPT->RESP, giving a fixed 3-cycle latency.
module imem_arb #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 18
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  output logic                  req0_ready,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_data,
  output logic                  rsp0_err,
  input  logic                  req1_valid,
  input  logic                  req1_we,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  req1_ready,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_data,
  output logic                  rsp1_err,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [MEM_DEPTH-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, ISSUE, CAPT, RESP} state_t;
  state_t state_q, state_d;
  logic last_q, last_d, port_q, port_d, we_q, we_d, fault_q, fault_d;
  logic [MEM_DEPTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, data_q, data_d;
  logic g1, acc, issue;
  logic [ADDR_WIDTH-1:0] sel_addr;
  // Port 1 wins only when alone or when port 0 was granted last.
  assign g1 = req1_valid & (~req0_valid | ~last_q);
  assign req0_ready = (state_q == IDLE) & req0_valid & ~g1;
  assign req1_ready = (state_q == IDLE) & g1;
  assign acc = req0_ready | req1_ready;
  assign sel_addr = g1 ? req1_addr : req0_addr;
  assign issue = (state_q == ISSUE) & ~fault_q;
  assign mem_en = issue;
  assign mem_we = issue & we_q;
  assign mem_addr = issue ? addr_q : '0;
  assign mem_wdata = issue ? wdata_q : '0;
  assign rsp0_valid = (state_q == RESP) & ~port_q;
  assign rsp1_valid = (state_q == RESP) & port_q;
  assign rsp0_data = rsp0_valid ? data_q : '0;
  assign rsp1_data = rsp1_valid ? data_q : '0;
  assign rsp0_err = rsp0_valid & fault_q;
  assign rsp1_err = rsp1_valid & fault_q;
  always_comb begin
    state_d = acc ? ISSUE : state_q == ISSUE ? CAPT : state_q == CAPT ? RESP : IDLE;
    last_d  = acc ? g1 : last_q;
    port_d  = acc ? g1 : port_q;
    we_d    = acc ? g1 & req1_we : we_q;
    addr_d  = acc ? sel_addr[MEM_DEPTH+1:2] : addr_q;
    wdata_d = acc ? (g1 ? req1_wdata : '0) : wdata_q;
    fault_d = acc ? (|sel_addr[1:0]) | (|(sel_addr >> (MEM_DEPTH + 2))) : fault_q;
    data_d  = state_q == CAPT ? ((fault_q | we_q) ? '0 : mem_rdata) : data_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      port_q  <= 1'b0;
      we_q    <= 1'b0;
      fault_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      port_q  <= port_d;
      we_q    <= we_d;
      fault_q <= fault_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
    end
  end
endmodule

// File: tb/tb_imem_arb.sv
// tb_imem_arb: directed checks of imem_arb against a small behavioural SRAM.
module tb_imem_arb;
  logic clk = 0, rst = 1;
  logic req0_valid = 0, req1_valid = 0, req1_we = 0;
  logic [31:0] req0_addr = 0, req1_addr = 0, req1_wdata = 0;
  logic req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
  logic [31:0] rsp0_data, rsp1_data, mem_wdata, mem_rdata;
  logic mem_en, mem_we;
  logic [17:0] mem_addr;
  logic [31:0] mem [0:15];
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  imem_arb dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(req0_ready),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_err(rsp1_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Synchronous SRAM: read data appears the cycle after mem_en.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr[3:0]] <= mem_wdata;
      mem_rdata <= mem[mem_addr[3:0]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic xact(input bit p, input bit we, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [31:0] ed, input bit ee,
                      input logic [31:0] ma);
    @(negedge clk);
    chk("idle_rsp0", {31'b0, rsp0_valid}, 0);
    chk("idle_rsp1", {31'b0, rsp1_valid}, 0);
    if (p) begin
      req1_valid = 1; req1_we = we; req1_addr = addr; req1_wdata = wd;
    end else begin
      req0_valid = 1; req0_addr = addr;
    end
    #1;
    chk("ready0", {31'b0, req0_ready}, {31'b0, !p});
    chk("ready1", {31'b0, req1_ready}, {31'b0, p});
    @(negedge clk);
    req0_valid = 0; req1_valid = 0; req1_we = 0;
    chk("issue_en", {31'b0, mem_en}, {31'b0, !ee});
    chk("issue_we", {31'b0, mem_we}, {31'b0, we && !ee});
    chk("issue_addr", {14'b0, mem_addr}, ma);
    chk("issue_wdata", mem_wdata, ee ? 32'h0 : wd);
    chk("issue_busy", {31'b0, req0_ready}, 0);
    @(negedge clk);
    chk("capt_en", {31'b0, mem_en}, 0);
    @(negedge clk);
    chk("resp_v0", {31'b0, rsp0_valid}, {31'b0, !p});
    chk("resp_v1", {31'b0, rsp1_valid}, {31'b0, p});
    chk("resp_data", p ? rsp1_data : rsp0_data, ed);
    chk("resp_err", {31'b0, p ? rsp1_err : rsp0_err}, {31'b0, ee});
    chk("resp_other", p ? rsp0_data : rsp1_data, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_en", {31'b0, mem_en}, 0);
    chk("rst_v0", {31'b0, rsp0_valid}, 0);
    chk("rst_v1", {31'b0, rsp1_valid}, 0);
    chk("rst_addr", {14'b0, mem_addr}, 0);
    chk("rst_d0", rsp0_data, 0);
    rst = 0;
    xact(1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 4);
    xact(1, 1, 32'h8, 32'h12345678, 0, 0, 2);
    xact(1, 1, 32'h14, 32'hCAFE0005, 0, 0, 5);
    xact(1, 1, 32'h000F_FFFC, 32'hA5A5A5A5, 0, 0, 32'h3FFFF);
    xact(0, 0, 32'h10, 0, 32'hDEADBEEF, 0, 4);
    xact(0, 0, 32'h8, 0, 32'h12345678, 0, 2);
    xact(0, 0, 32'h000F_FFFC, 0, 32'hA5A5A5A5, 0, 32'h3FFFF);
    xact(0, 0, 32'h6, 0, 0, 1, 0);
    xact(0, 0, 32'h0100_0000, 0, 0, 1, 0);
    xact(0, 0, 32'h0010_0000, 0, 0, 1, 0);
    xact(1, 1, 32'h3, 32'hFFFFFFFF, 0, 1, 0);
    xact(1, 0, 32'h14, 0, 32'hCAFE0005, 0, 5);
    xact(0, 0, 32'h10, 0, 32'hDEADBEEF, 0, 4);
    // Reset while the memory strobe is high must drop it at once.
    @(negedge clk);
    req0_valid = 1; req0_addr = 32'h10;
    @(negedge clk);
    req0_valid = 0;
    chk("pre_rst_en", {31'b0, mem_en}, 1);
    #1 rst = 1;
    #1;
    chk("rst_issue_en", {31'b0, mem_en}, 0);
    chk("rst_issue_addr", {14'b0, mem_addr}, 0);
    @(negedge clk);
    rst = 0;
    repeat (4) begin
      @(negedge clk);
      chk("abort1_v0", {31'b0, rsp0_valid}, 0);
    end
    // Reset during CAPT after a port-0 grant, then a tie must go to port 0.
    req0_valid = 1; req0_addr = 32'h10;
    @(negedge clk);
    req0_valid = 0;
    @(negedge clk);
    #1 rst = 1;
    #1;
    chk("rst_capt_en", {31'b0, mem_en}, 0);
    @(negedge clk);
    rst = 0;
    repeat (4) begin
      @(negedge clk);
      chk("abort2_v0", {31'b0, rsp0_valid}, 0);
      chk("abort2_v1", {31'b0, rsp1_valid}, 0);
    end
    req0_valid = 1; req0_addr = 32'h10;
    req1_valid = 1; req1_we = 0; req1_addr = 32'h14; req1_wdata = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("alt_ready0", {31'b0, req0_ready}, {31'b0, i % 2 == 0});
      chk("alt_ready1", {31'b0, req1_ready}, {31'b0, i % 2 == 1});
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        chk("alt_busy", {30'b0, req0_ready, req1_ready}, 0);
      end
      chk("alt_v0", {31'b0, rsp0_valid}, {31'b0, i % 2 == 0});
      chk("alt_v1", {31'b0, rsp1_valid}, {31'b0, i % 2 == 1});
      chk("alt_data", (i % 2 == 0) ? rsp0_data : rsp1_data,
          (i % 2 == 0) ? 32'hDEADBEEF : 32'hCAFE0005);
      @(negedge clk);
    end
    req0_valid = 0; req1_valid = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
